mem_responder: RTL and testbench

//  Memory-side responder for the multicycle controller's strobes (mem_e, mem_w).

---
 rtl/proc_pkg.sv | 12 +
 rtl/mem_array.sv | 29 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared widths and the memory-responder state type used by the controller and memory side.
package proc_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } mem_state_t;
endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered read, contents never reset.
module mem_array #(
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx;

  // Range is enforced by the responder; only the implemented index bits reach the array.
  assign idx   = addr[IDX_W-1:0];
  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata_q <= mem[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request, inserts WAIT_CYC wait states, does one RAM access,
// then pulses ready (and err for out-of-range addresses) for one cycle.
// Handshake: mem_e is a level request sampled only in IDLE together with mem_w/addr/wdata;
// the requester holds it until it sees ready, and mem_e still high in the IDLE after RESP starts a new request.
module mem_responder #(
  parameter int ADDR_W   = proc_pkg::ADDR_W,
  parameter int DATA_W   = proc_pkg::DATA_W,
  parameter int DEPTH    = 4096,
  parameter int WAIT_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_e,
  input  logic                 mem_w,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata,
  output logic                 ready,
  output logic                 err,
  output logic                 busy,
  output proc_pkg::mem_state_t dbg_state
);
  import proc_pkg::*;

  localparam logic [3:0]      WAIT_LAST = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Full-width compare so addresses above DEPTH never alias onto implemented words.
  assign in_range = {1'b0, addr_q} < DEPTH_X;

  // The RAM reads one cycle ahead of ACCESS: straight from addr on acceptance (needed when
  // WAIT_CYC=0), from the latched address afterwards.
  assign ram_addr = (state_q == IDLE) ? addr : addr_q;
  assign ram_we   = (state_q == ACCESS) && write_q && in_range && !rst;

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_e) begin
          addr_d  = addr;
          wdata_d = wdata;
          write_d = mem_w;
          cnt_d   = 4'd0;
          state_d = (WAIT_CYC == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!write_q) begin
          rdata_d = in_range ? ram_rdata : '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RESP);
    err_d   = (state_d == RESP) && !in_range;
    busy_d  = (state_d == WAIT) || (state_d == ACCESS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model of the main instance checked every cycle,
// plus directed latency checks on WAIT_CYC=0 and WAIT_CYC=15 instances.
`timescale 1ns/1ps
module tb_mem_responder;
  import proc_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int D0 = 1024;
  localparam int W0 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance: DEPTH=1024, WAIT_CYC=2
  logic          e0, w0, r0, er0, b0;
  logic [AW-1:0] a0;
  logic [DW-1:0] d0, rd0;
  mem_state_t    st0;

  // side instances: [0] WAIT_CYC=0, [1] WAIT_CYC=15
  logic          e_x [2];
  logic          w_x [2];
  logic [AW-1:0] a_x [2];
  logic [DW-1:0] d_x [2];
  logic [DW-1:0] rd_x[2];
  logic          r_x [2];
  logic          er_x[2];
  logic          b_x [2];
  mem_state_t    st_x[2];

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D0), .WAIT_CYC(W0)) u0 (
    .clk(clk), .rst(rst), .mem_e(e0), .mem_w(w0), .addr(a0), .wdata(d0),
    .rdata(rd0), .ready(r0), .err(er0), .busy(b0), .dbg_state(st0));

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4096), .WAIT_CYC(0)) u1 (
    .clk(clk), .rst(rst), .mem_e(e_x[0]), .mem_w(w_x[0]), .addr(a_x[0]), .wdata(d_x[0]),
    .rdata(rd_x[0]), .ready(r_x[0]), .err(er_x[0]), .busy(b_x[0]), .dbg_state(st_x[0]));

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4096), .WAIT_CYC(15)) u2 (
    .clk(clk), .rst(rst), .mem_e(e_x[1]), .mem_w(w_x[1]), .addr(a_x[1]), .wdata(d_x[1]),
    .rdata(rd_x[1]), .ready(r_x[1]), .err(er_x[1]), .busy(b_x[1]), .dbg_state(st_x[1]));

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  // Each accepted request {w, addr, wdata} waits in exp_q; it completes W0+2 edges after
  // acceptance, busy covers the edges in between, and memory/rdata update on completion.
  logic [DW-1:0]      mem_m [D0];
  logic [AW+DW:0]     exp_q [$];
  int                 k = 0;
  bit                 m_valid = 1'b0;
  logic               m_ready, m_err, m_busy;
  logic [DW-1:0]      m_rdata;

  always @(posedge clk) begin
    logic          tw;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    if (rst) begin
      k = 0;
      exp_q.delete();
      m_ready = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_rdata = '0;
      m_valid = 1'b1;
    end else begin
      m_ready = 1'b0;
      m_err   = 1'b0;
      if (k == 0) begin
        if (e0) begin
          exp_q.push_back({w0, a0, d0});
          k = 1;
        end
      end else if (k == W0 + 2) begin
        k = 0;
      end else begin
        k++;
      end
      if (k == W0 + 2) begin
        {tw, ta, td} = exp_q.pop_front();
        m_ready = 1'b1;
        m_err   = (int'(ta) >= D0);
        if (int'(ta) < D0) begin
          if (tw) mem_m[int'(ta)] = td;
          else    m_rdata = mem_m[int'(ta)];
        end else if (!tw) begin
          m_rdata = '0;
        end
      end
      m_busy = (k >= 1) && (k <= W0 + 1);
    end
  end

  // single compare process for the main instance
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_ready", r0,  m_ready);
      check("cyc_err",   er0, m_err);
      check("cyc_busy",  b0,  m_busy);
      check("cyc_rdata", rd0, m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit hold, input bit churn,
                     output int lat, output logic [DW-1:0] rd, output logic er, output int rcyc);
    bit cont;
    bit got;
    cont = e0;
    got  = 1'b0;
    lat  = 0;
    e0 = 1'b1; w0 = w; a0 = a; d0 = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (r0) got = 1'b1;
      else if (churn && lat >= 1 + int'(cont)) begin
        a0 = AW'($urandom);
        d0 = DW'($urandom);
      end
    end
    if (cont) lat--;
    check("req_ready_seen", got, 1);
    check("req_latency", lat, W0 + 2);
    rd   = rd0;
    er   = er0;
    rcyc = cyc;
    if (!hold) begin
      e0 = 1'b0; w0 = 1'($urandom); a0 = AW'($urandom); d0 = DW'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic req_x(input int n, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int lat, output logic [DW-1:0] rd);
    bit got;
    got = 1'b0;
    lat = 0;
    e_x[n] = 1'b1; w_x[n] = w; a_x[n] = a; d_x[n] = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (r_x[n]) got = 1'b1;
    end
    check("x_ready_seen", got, 1);
    rd = rd_x[n];
    e_x[n] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            lat, c1, c2, nready;
    logic [DW-1:0] rd;
    logic          er;
    logic [AW-1:0] pa;

    rst = 1'b1; e0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    for (int n = 0; n < 2; n++) begin
      e_x[n] = 1'b0; w_x[n] = 1'b0; a_x[n] = '0; d_x[n] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", r0, 0);
    check("rst_busy",  b0, 0);
    check("rst_err",   er0, 0);
    check("rst_rdata", rd0, 0);
    check("rst_x0_busy", b_x[0], 0);
    check("rst_x1_rdata", rd_x[1], 0);
    rst = 1'b0;

    // write then read
    req(1, 12'h010, 16'hBEEF, 0, 0, lat, rd, er, c1);
    check("t1_wr_lat", lat, 4);
    check("t1_wr_err", er, 0);
    req(0, 12'h010, 16'h0000, 0, 0, lat, rd, er, c1);
    check("t1_rd_data", rd, 16'hBEEF);
    check("t1_rd_lat", lat, 4);
    check("t1_rd_err", er, 0);

    // back-to-back reads with mem_e held high
    req(1, 12'h000, 16'h1234, 0, 0, lat, rd, er, c1);
    req(1, 12'h001, 16'hABCD, 0, 0, lat, rd, er, c1);
    req(0, 12'h000, 16'h0000, 1, 0, lat, rd, er, c1);
    check("t2_rd0_data", rd, 16'h1234);
    req(0, 12'h001, 16'h0000, 0, 0, lat, rd, er, c2);
    check("t2_rd1_data", rd, 16'hABCD);
    check("t2_spacing", c2 - c1, 5);

    // out of range and boundary
    req(1, 12'h400, 16'h5555, 0, 0, lat, rd, er, c1);
    check("t3_wr_oor_err", er, 1);
    req(1, 12'hC00, 16'h9999, 0, 0, lat, rd, er, c1);
    req(0, 12'h000, 16'h0000, 0, 0, lat, rd, er, c1);
    check("t3_rd0_kept", rd, 16'h1234);
    check("t3_rd0_err", er, 0);
    req(0, 12'h400, 16'h0000, 0, 0, lat, rd, er, c1);
    check("t3_rd_oor_data", rd, 16'h0000);
    check("t3_rd_oor_err", er, 1);
    req(1, 12'h3FF, 16'h0F0F, 0, 0, lat, rd, er, c1);
    req(0, 12'h3FF, 16'h0000, 0, 0, lat, rd, er, c1);
    check("t3_last_word", rd, 16'h0F0F);
    check("t3_last_err", er, 0);

    // reset while a write is in WAIT
    req(1, 12'h020, 16'h1111, 0, 0, lat, rd, er, c1);
    e0 = 1'b1; w0 = 1'b1; a0 = 12'h020; d0 = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; e0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t4_busy_after_rst", b0, 0);
    check("t4_rdata_after_rst", rd0, 0);
    rst = 1'b0;
    nready = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (r0) nready++;
    end
    check("t4_no_ready", nready, 0);
    // rst together with mem_e: request must not be taken
    rst = 1'b1; e0 = 1'b1; w0 = 1'b1; a0 = 12'h020; d0 = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; e0 = 1'b0;
    @(negedge clk);
    check("t4_rst_wins_busy", b0, 0);
    req(0, 12'h020, 16'h0000, 0, 0, lat, rd, er, c1);
    check("t4_old_value", rd, 16'h1111);

    // input churn during WAIT
    req(1, 12'h030, 16'hC0DE, 0, 1, lat, rd, er, c1);
    req(0, 12'h030, 16'h0000, 0, 1, lat, rd, er, c1);
    check("t6_churn_data", rd, 16'hC0DE);

    // randomized traffic over a small pool of addresses
    for (int i = 0; i < 16; i++) begin
      req(1, AW'(i), DW'($urandom), 0, 0, lat, rd, er, c1);
    end
    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 16)       pa = AW'(sel);
      else if (sel == 16) pa = 12'h3FF;
      else if (sel == 17) pa = 12'h400;
      else if (sel == 18) pa = 12'hFFF;
      else                pa = AW'($urandom_range(1024, 4095));
      req(1'($urandom_range(0, 1)), pa, DW'($urandom), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), lat, rd, er, c1);
      if (!e0) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req(0, 12'h000, 16'h0000, 0, 0, lat, rd, er, c1);

    // side instances: WAIT_CYC=0 and WAIT_CYC=15
    req_x(0, 1, 12'h050, 16'hCAFE, lat, rd);
    check("t5_w0_wr_lat", lat, 2);
    req_x(0, 0, 12'h050, 16'h0000, lat, rd);
    check("t5_w0_rd_lat", lat, 2);
    check("t5_w0_rd_data", rd, 16'hCAFE);
    req_x(1, 1, 12'hFFF, 16'h4321, lat, rd);
    check("t5_w15_wr_lat", lat, 17);
    req_x(1, 0, 12'hFFF, 16'h0000, lat, rd);
    check("t5_w15_rd_lat", lat, 17);
    check("t5_w15_rd_data", rd, 16'h4321);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles required fewer", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
